// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the program counter and presents it to a combinational instruction
// memory. The returned word is captured into the IF/ID register together
// with pc+4. Stall, flush and ID redirects (taken branch, j, jal, jr) are
// applied at the clock edge. Branches have a single delay slot, so a
// redirect changes only the next pc and never touches IF/ID.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides all other inputs
//   stall        hold pc and IF/ID (load-use hazard)
//   flush        load a bubble (nop, valid=0) into IF/ID; beats stall
//   redirect     ID resolved a taken control transfer
//   redirect_pc  target address for redirect
//   instIn       instruction word at pc (combinational memory)
//   pc           current fetch address, always word aligned
//   if_id_inst   registered instruction
//   if_id_pc4    registered fetch address + 4
//   if_id_valid  IF/ID holds a real instruction
//   misaligned   sticky: an accepted redirect target had bits [1:0] != 0
//   fetch_count  saturating count of instructions captured into IF/ID
//   stall_count  saturating count of stalled cycles
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic [31:0]          instIn,
  output logic [31:0]          pc,
  output logic [31:0]          if_id_inst,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0] pc_reg, pc_next, pc_plus4;
  logic [31:0] inst_reg, pc4_reg;
  logic        valid_reg;
  logic        misaligned_reg, misaligned_next;
  logic        load_ifid;
  logic [1:0]  cnt_inc;

  assign pc_plus4  = pc_reg + 32'd4;   // modulo 2^32: 0xFFFFFFFC wraps to 0
  assign load_ifid = !flush && !stall;

  // A redirect seen during a stall is dropped; ID presents it again once
  // the stall releases, so it must not move pc or flag misalignment now.
  always_comb begin
    pc_next         = pc_plus4;
    misaligned_next = misaligned_reg;
    if (stall) begin
      pc_next = pc_reg;
    end else if (redirect) begin
      pc_next         = {redirect_pc[31:2], 2'b00};
      misaligned_next = misaligned_reg | (|redirect_pc[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= {RESET_PC[31:2], 2'b00};
      misaligned_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      misaligned_reg <= misaligned_next;
    end
  end

  // IF/ID: flush beats stall; the delay-slot word is captured normally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inst_reg  <= 32'h0;
      pc4_reg   <= 32'h0;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      inst_reg  <= instIn;
      pc4_reg   <= pc_plus4;
      valid_reg <= 1'b1;
    end
  end

  // Counter 0 counts IF/ID loads, counter 1 counts stalled cycles
  // (stall+flush included). Both stick at all-ones.
  assign cnt_inc[0] = load_ifid;
  assign cnt_inc[1] = stall;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
    end
  endgenerate

  assign pc          = pc_reg;
  assign if_id_inst  = inst_reg;
  assign if_id_pc4   = pc4_reg;
  assign if_id_valid = valid_reg;
  assign misaligned  = misaligned_reg;
  assign fetch_count = g_cnt[0].cnt_reg;
  assign stall_count = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Directed vectors are applied on the
// falling edge; each vector pushes its hand-computed post-edge state into a
// queue. A monitor samples 1 time unit after every rising edge and pops and
// compares one entry per presented cycle. Counters are built 3 bits wide so
// fetch_count saturation at 7 is reached by the directed sequence.
module tb_fetch_stage;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic [31:0]   instIn;
  logic [31:0]   pc;
  logic [31:0]   if_id_inst;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
  logic          misaligned;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h00000000), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .instIn(instIn),
    .pc(pc), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .misaligned(misaligned),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  // Program image: unlisted addresses read back as 0x0bad_<addr[15:0]>.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00: imem = 32'h3c010000;
      32'h04: imem = 32'h34240050;
      32'h08: imem = 32'h0c00001b;   // jal 0x6c
      32'h0c: imem = 32'h20050004;   // delay slot
      32'h6c: imem = 32'h00004020;
      32'h70: imem = 32'h8c890000;
      32'h74: imem = 32'h01094020;
      default: imem = {16'h0bad, a[15:0]};
    endcase
  endfunction

  assign instIn = imem(pc);

  typedef struct {
    string       tag;
    logic        rst, stall, flush, redir;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_inst, e_pc4;
    logic        e_v, e_m;
    logic [31:0] e_fc, e_sc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic v(input string tag, input logic r, input logic s,
                   input logic f, input logic rd, input logic [31:0] rpc,
                   input logic [31:0] e_pc, input logic [31:0] e_inst,
                   input logic [31:0] e_pc4, input logic e_v, input logic e_m,
                   input logic [31:0] e_fc, input logic [31:0] e_sc);
    vec_t x;
    x.tag = tag; x.rst = r; x.stall = s; x.flush = f; x.redir = rd;
    x.rpc = rpc; x.e_pc = e_pc; x.e_inst = e_inst; x.e_pc4 = e_pc4;
    x.e_v = e_v; x.e_m = e_m; x.e_fc = e_fc; x.e_sc = e_sc;
    vecs.push_back(x);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", tag, fld, act, exp);
    end
  endtask

  // Monitor: every cycle is a presentation; compare against the head entry.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "pc",    pc,                   e.e_pc);
        chk(e.tag, "inst",  if_id_inst,           e.e_inst);
        chk(e.tag, "pc4",   if_id_pc4,            e.e_pc4);
        chk(e.tag, "valid", {31'b0, if_id_valid}, {31'b0, e.e_v});
        chk(e.tag, "mis",   {31'b0, misaligned},  {31'b0, e.e_m});
        chk(e.tag, "fcnt",  32'(fetch_count),     e.e_fc);
        chk(e.tag, "scnt",  32'(stall_count),     e.e_sc);
        $display("txn %-10s pc=%08h inst=%08h pc4=%08h v=%0b mis=%0b fc=%0d sc=%0d",
                 e.tag, pc, if_id_inst, if_id_pc4, if_id_valid, misaligned,
                 fetch_count, stall_count);
      end
    end
  end

  initial begin
    //  tag          rst stl fl rd rpc            pc            inst          pc4           v  m  fc sc
    v("reset",      1, 0, 0, 0, 32'h0,        32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 0);
    v("run1",       0, 0, 0, 0, 32'h0,        32'h00000004, 32'h3c010000, 32'h00000004, 1, 0, 1, 0);
    v("run2",       0, 0, 0, 0, 32'h0,        32'h00000008, 32'h34240050, 32'h00000008, 1, 0, 2, 0);
    v("jal_fetch",  0, 0, 0, 0, 32'h0,        32'h0000000c, 32'h0c00001b, 32'h0000000c, 1, 0, 3, 0);
    v("dslot",      0, 0, 0, 1, 32'h6c,       32'h0000006c, 32'h20050004, 32'h00000010, 1, 0, 4, 0);
    v("target",     0, 0, 0, 0, 32'h0,        32'h00000070, 32'h00004020, 32'h00000070, 1, 0, 5, 0);
    v("pre_stall",  0, 0, 0, 0, 32'h0,        32'h00000074, 32'h8c890000, 32'h00000074, 1, 0, 6, 0);
    v("stall1",     0, 1, 0, 0, 32'h0,        32'h00000074, 32'h8c890000, 32'h00000074, 1, 0, 6, 1);
    v("stall2",     0, 1, 0, 0, 32'h0,        32'h00000074, 32'h8c890000, 32'h00000074, 1, 0, 6, 2);
    v("release",    0, 0, 0, 0, 32'h0,        32'h00000078, 32'h01094020, 32'h00000078, 1, 0, 7, 2);
    v("st_rd_mis",  0, 1, 0, 1, 32'h23,       32'h00000078, 32'h01094020, 32'h00000078, 1, 0, 7, 3);
    v("st_rd",      0, 1, 0, 1, 32'h20,       32'h00000078, 32'h01094020, 32'h00000078, 1, 0, 7, 4);
    v("rd_after",   0, 0, 0, 1, 32'h20,       32'h00000020, 32'h0bad0078, 32'h0000007c, 1, 0, 7, 4);
    v("misalign",   0, 0, 0, 1, 32'h4e,       32'h0000004c, 32'h0bad0020, 32'h00000024, 1, 1, 7, 4);
    v("flush",      0, 0, 1, 0, 32'h0,        32'h00000050, 32'h00000000, 32'h00000000, 0, 1, 7, 4);
    v("post_flush", 0, 0, 0, 0, 32'h0,        32'h00000054, 32'h0bad0050, 32'h00000054, 1, 1, 7, 4);
    v("st_fl_rd",   0, 1, 1, 1, 32'h100,      32'h00000054, 32'h00000000, 32'h00000000, 0, 1, 7, 5);
    v("rst_pend",   1, 1, 0, 1, 32'h200,      32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 0);
    v("after_rst",  0, 0, 0, 0, 32'h0,        32'h00000004, 32'h3c010000, 32'h00000004, 1, 0, 1, 0);
    v("rd_top",     0, 0, 0, 1, 32'hfffffffc, 32'hfffffffc, 32'h34240050, 32'h00000008, 1, 0, 2, 0);
    v("wrap",       0, 0, 0, 0, 32'h0,        32'h00000000, 32'h0badfffc, 32'h00000000, 1, 0, 3, 0);
    v("post_wrap",  0, 0, 0, 0, 32'h0,        32'h00000004, 32'h3c010000, 32'h00000004, 1, 0, 4, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      stall       = vecs[i].stall;
      flush       = vecs[i].flush;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;

    // Bounded drain of the scoreboard.
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives it to the combinational instruction memory. It captures the returned word into the IF/ID pipeline register together with PC+4, and applies stall, flush and branch/jump redirects from ID. It uses single-delay-slot semantics: the instruction after a branch or jump is always fetched and executed, and is never squashed by a redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
CNT_WIDTH, 32, width of the performance counters.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard unit load-use stall: hold PC and IF/ID.
flush  in  1  force a bubble (nop, valid=0) into IF/ID at the next edge.
redirect  in  1  ID resolved a taken branch, j, jal or jr.
redirect_pc  in  32  target address for redirect.
instIn  in  32  instruction word from instruction memory (combinational, same cycle as pc).
pc  out  32  current fetch address, to instruction memory.
if_id_inst  out  32  registered instruction, to ID.
if_id_pc4  out  32  registered fetch address + 4, for the jal link value and branch base.
if_id_valid  out  1  IF/ID holds a real instruction.
misaligned  out  1  sticky flag: a redirect target had bits [1:0] != 0.
fetch_count  out  CNT_WIDTH  instructions captured into IF/ID.
stall_count  out  CNT_WIDTH  cycles spent stalled.

Behaviour:
- Reset (sampled at posedge while rst=1):
  - pc=RESET_PC; if_id_inst=0 (nop); if_id_pc4=0; if_id_valid=0.
  - misaligned=0; fetch_count=0; stall_count=0.
  - Reset mid-operation discards everything, including a pending redirect. rst overrides every other input.
- Next-PC priority, evaluated each posedge when rst=0:
  - stall=1: pc holds. A redirect in the same cycle is ignored, because ID re-presents it after the stall.
  - else redirect=1: pc = {redirect_pc[31:2],2'b00}. misaligned is set if redirect_pc[1:0]!=0.
  - else: pc = pc+4. Arithmetic is 32-bit modulo; 0xFFFFFFFC wraps to 0.
- IF/ID register priority, evaluated each posedge when rst=0:
  - flush=1: inst=0, pc4=0, valid=0. flush beats stall.
  - else stall=1: all IF/ID fields hold.
  - else: inst=instIn, pc4=pc+4, valid=1.
- Delay slot: redirect does not affect IF/ID.
  - The instruction fetched in the same cycle the redirect is asserted (the delay slot) is captured normally.
  - The target is fetched in the following cycle.
- Latency: instruction at address A appears in if_id_inst exactly one edge after pc==A, provided no stall or flush.
- Counters:
  - fetch_count increments on every edge where IF/ID loads instIn (no rst, flush or stall).
  - stall_count increments on every edge with stall=1 and rst=0, including stall+flush.
  - Both saturate at all-ones and do not wrap.
- pc[1:0] is always 00. The low two bits of pc never become non-zero.
- Simultaneous stall+flush+redirect: pc holds, IF/ID gets a bubble, stall_count increments, redirect is dropped, misaligned is unchanged.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset then run 3 cycles with the standard program.
   - After the reset edge: pc=0, valid=0.
   - Edge 1: if_id_inst=0x3c010000, if_id_pc4=0x4, pc=0x4.
   - Edge 2: if_id_inst=0x34240050, pc=0x8.
   - fetch_count=2.
2. jal at 0x08, with redirect=1 and redirect_pc=0x6c asserted while pc=0x0c.
   - Next edge: IF/ID gets the delay slot 0x20050004, pc=0x6c.
   - Following edge: if_id_inst=0x00004020.
3. stall=1 for 2 cycles while pc=0x74 and if_id_inst=0x8c890000.
   - pc and IF/ID hold for 2 edges; stall_count=2.
   - After release: if_id_inst=0x01094020, pc=0x78.
4. stall=1 and redirect=1 (redirect_pc=0x20) in the same cycle.
   - pc holds.
   - Next cycle, redirect alone: pc=0x20.
5. redirect_pc=0x4e: pc=0x4c and misaligned=1. misaligned stays 1 until rst. flush=1 alone: valid=0 and inst=0 while pc still advances by 4.
6. Assert rst mid-stall with a pending redirect.
   - pc=RESET_PC, valid=0, counters=0.
   - With pc=0xFFFFFFFC forced via redirect, the next normal edge gives pc=0x00000000.
